io_channel_bank: RTL

Parametrised LED/sensor peripheral bank driven by the execute stage's led and cap instructions. It generalises the fixed 9-channel LED/sensor select to N channels. It adds registered sensor sampling, a programmable touch threshold with per-channel debounce, sticky touch-event flags with read-to-clear, an interrupt line, and out-of-range index detection. All state is clocked on posedge clock.

---
 rtl/io_channel_bank.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/io_channel_bank.sv
// io_channel_bank
//   LED/sensor peripheral bank serving the execute stage's led and cap
//   instructions across N_CH channels. Raw sensor values are registered,
//   compared against a programmable threshold, debounced per channel, and
//   rising touch edges latch sticky pending flags that raise irq.
//
// Ports
//   clock, reset_n            clock and asynchronous active-low reset
//   led_we/led_idx/led_data   write one LED command slice
//   cap_re/cap_idx/cap_mode   read request (raw sample, touch bitmap,
//                             pending read-and-clear, reserved)
//   thr_we/thr_data           threshold load
//   sensor_readings           packed raw sensor values
//   led_commands              packed LED command registers
//   cap_data/cap_valid        read result (held) and one-cycle valid pulse
//   touch_state               debounced touch state per channel
//   irq                       registered OR of pending flags
//   idx_error                 pulse on an out-of-range led or raw cap index
module io_channel_bank #(
    parameter int N_CH    = 9,
    parameter int LED_W   = 16,
    parameter int SENS_W  = 32,
    parameter int IDX_W   = 4,
    parameter int DEB_LEN = 4,
    parameter int THR_RST = 100
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     led_we,
    input  logic [IDX_W-1:0]         led_idx,
    input  logic [LED_W-1:0]         led_data,
    input  logic                     cap_re,
    input  logic [IDX_W-1:0]         cap_idx,
    input  logic [1:0]               cap_mode,
    input  logic                     thr_we,
    input  logic [SENS_W-1:0]        thr_data,
    input  logic [N_CH*SENS_W-1:0]   sensor_readings,
    output logic [N_CH*LED_W-1:0]    led_commands,
    output logic [SENS_W-1:0]        cap_data,
    output logic                     cap_valid,
    output logic [N_CH-1:0]          touch_state,
    output logic                     irq,
    output logic                     idx_error
);

    localparam logic [IDX_W:0]    NCH_C = (IDX_W+1)'(N_CH);
    localparam logic [3:0]        DEB_C = 4'(DEB_LEN);
    localparam logic [SENS_W-1:0] THR_C = SENS_W'(THR_RST);

    logic [N_CH*LED_W-1:0]  led_q, led_d;
    logic [N_CH*SENS_W-1:0] sample_q;
    logic [SENS_W-1:0]      thr_q, thr_d;
    logic [N_CH*4-1:0]      cnt_q, cnt_d;
    logic [N_CH-1:0]        ts_q, ts_d;
    logic [N_CH-1:0]        pend_q, pend_d;
    logic [SENS_W-1:0]      capd_q, capd_d;
    logic                   capv_q;
    logic                   irq_q;
    logic                   iderr_q, iderr_d;

    logic                   led_ok, cap_ok;
    logic [SENS_W-1:0]      raw_sel;
    logic [N_CH-1:0]        rise, clr;
    logic                   raw;
    logic [3:0]             cnt_inc;

    assign led_ok = {1'b0, led_idx} < NCH_C;
    assign cap_ok = {1'b0, cap_idx} < NCH_C;

    // LED slice write and raw-read mux; an out-of-range index matches no slice
    always_comb begin
        led_d   = led_q;
        raw_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (led_we && (led_idx == i[IDX_W-1:0]))
                led_d[i*LED_W +: LED_W] = led_data;
            if (cap_idx == i[IDX_W-1:0])
                raw_sel = sample_q[i*SENS_W +: SENS_W];
        end
    end

    // Debounce: a flip needs DEB_LEN consecutive samples disagreeing with
    // the current state; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        raw     = 1'b0;
        cnt_inc = '0;
        for (int i = 0; i < N_CH; i++) begin
            raw     = sample_q[i*SENS_W +: SENS_W] >= thr_q;
            cnt_inc = cnt_q[i*4 +: 4] + 4'd1;
            if (raw == ts_q[i]) begin
                cnt_d[i*4 +: 4] = '0;
            end else if (cnt_inc == DEB_C) begin
                cnt_d[i*4 +: 4] = '0;
                ts_d[i]         = ~ts_q[i];
            end else begin
                cnt_d[i*4 +: 4] = cnt_inc;
            end
        end
    end

    // Only bits actually returned by the read are cleared, so an event
    // landing on the clearing edge survives.
    always_comb begin
        rise   = ts_d & ~ts_q;
        clr    = (cap_re && (cap_mode == 2'b10)) ? pend_q : '0;
        pend_d = (pend_q & ~clr) | rise;
        thr_d  = thr_we ? thr_data : thr_q;
    end

    always_comb begin
        capd_d  = capd_q;
        iderr_d = (led_we && !led_ok) || (cap_re && (cap_mode == 2'b00) && !cap_ok);
        if (cap_re) begin
            capd_d = '0;
            case (cap_mode)
                2'b00:   capd_d = cap_ok ? raw_sel : '0;
                2'b01:   capd_d[N_CH-1:0] = ts_q;
                2'b10:   capd_d[N_CH-1:0] = pend_q;
                default: capd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_q    <= '0;
            sample_q <= '0;
            thr_q    <= THR_C;
            cnt_q    <= '0;
            ts_q     <= '0;
            pend_q   <= '0;
            capd_q   <= '0;
            capv_q   <= 1'b0;
            irq_q    <= 1'b0;
            iderr_q  <= 1'b0;
        end else begin
            led_q    <= led_d;
            sample_q <= sensor_readings;
            thr_q    <= thr_d;
            cnt_q    <= cnt_d;
            ts_q     <= ts_d;
            pend_q   <= pend_d;
            capd_q   <= capd_d;
            capv_q   <= cap_re;
            irq_q    <= |pend_q;
            iderr_q  <= iderr_d;
        end
    end

    assign led_commands = led_q;
    assign cap_data     = capd_q;
    assign cap_valid    = capv_q;
    assign touch_state  = ts_q;
    assign irq          = irq_q;
    assign idx_error    = iderr_q;

endmodule
